spi_regfile_slave: RTL and testbench

//  SPI mode-0 slave giving a host indexed read/write access to NREG control registers and NREG read-only status words.

---
 rtl/spi_regfile_slave_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 28 ++
 rtl/spi_regfile_slave.sv | 169 ++++++++++++++++
 tb/tb_spi_regfile_slave.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/spi_regfile_slave_pkg.sv
// rtl/spi_regfile_slave_pkg.sv - shared FSM encoding and constants for the SPI register-file slave
package spi_regfile_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [7:0] STATUS_MAGIC_DEF = 8'hA0;

  // The read/write flag is the MSB of the command word.
  function automatic int cmd_wr_bit(input int data_w);
    return data_w - 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-FF synchroniser with rise/fall pulse outputs
module spi_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // Resetting low means a select already held low at reset release never looks like a fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_regfile_slave.sv
// rtl/spi_regfile_slave.sv - SPI mode-0 slave with NREG control registers and NREG status words
// Optional write-strobe output enabled by SPIREG_WSTROBE_EN.
module spi_regfile_slave
  import spi_regfile_slave_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                NREG         = 4,
  parameter int                MUX_W        = 2,
  parameter logic [DATA_W-1:0] STATUS_MAGIC = DATA_W'(STATUS_MAGIC_DEF)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ss,
  input  logic                   sclk,
  input  logic                   mosi,
  output logic                   miso,
  output logic                   miso_oe,
  output logic [MUX_W-1:0]       mux,
  output logic [NREG*DATA_W-1:0] regs_out,
  input  logic [NREG*DATA_W-1:0] stat_in
`ifdef SPIREG_WSTROBE_EN
  ,
  output logic [NREG-1:0]        wstrobe
`endif
);

  localparam int AW     = DATA_W - 1;
  localparam int CW     = $clog2(DATA_W);
  localparam int WR_BIT = cmd_wr_bit(DATA_W);

  state_t              state;
  logic [CW-1:0]       bit_cnt;
  logic [DATA_W-2:0]   rx_sh;
  logic [DATA_W-1:0]   tx_sh;
  logic [AW-1:0]       addr;
  logic                is_wr;
  logic                err;
  logic                wr_pend;
  logic [AW-1:0]       wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   regs [NREG];

  logic ss_rise, ss_fall, sclk_rise, sclk_fall;
  logic mosi_s1, mosi_s;

  spi_sync_edge u_ss_sync (
    .clk(clk), .reset_n(reset_n), .din(ss), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge u_sclk_sync (
    .clk(clk), .reset_n(reset_n), .din(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mosi_s1 <= 1'b0;
      mosi_s  <= 1'b0;
    end else begin
      mosi_s1 <= mosi;
      mosi_s  <= mosi_s1;
    end
  end

  logic [DATA_W-1:0] rx_word;
  logic              last_bit;
  logic [AW-1:0]     next_addr;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;

  assign rx_word   = {rx_sh, mosi_s};
  assign last_bit  = (bit_cnt == CW'(DATA_W - 1));
  assign next_addr = (addr == AW'(2 * NREG - 1)) ? '0 : addr + AW'(1);
  // Command word: readback starts at the commanded address; data word: at the next one.
  assign rd_addr   = (state == ST_CMD) ? rx_word[AW-1:0] : next_addr;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_addr == AW'(i))        rd_data = regs[i];
      if (rd_addr == AW'(NREG + i)) rd_data = stat_in[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      rx_sh   <= '0;
      tx_sh   <= '0;
      addr    <= '0;
      is_wr   <= 1'b0;
      err     <= 1'b0;
      miso_oe <= 1'b0;
      wr_pend <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_pend <= 1'b0;
      if (ss_rise) begin
        // Deselect beats any coincident sclk edge; a partial word is dropped and flagged.
        if (state != ST_IDLE && bit_cnt != '0) err <= 1'b1;
        state   <= ST_IDLE;
        bit_cnt <= '0;
        miso_oe <= 1'b0;
      end else if (ss_fall && state == ST_IDLE) begin
        state   <= ST_CMD;
        bit_cnt <= '0;
        miso_oe <= 1'b1;
        tx_sh   <= {STATUS_MAGIC[DATA_W-1:1], err};
        err     <= 1'b0;
      end else if (state != ST_IDLE) begin
        if (sclk_rise) begin
          rx_sh <= rx_word[DATA_W-2:0];
          if (last_bit) begin
            bit_cnt <= '0;
            tx_sh   <= rd_data;
            if (state == ST_CMD) begin
              is_wr <= rx_word[WR_BIT];
              addr  <= rx_word[AW-1:0];
              state <= ST_DATA;
            end else begin
              wr_pend <= is_wr && (addr < AW'(NREG));
              wr_addr <= addr;
              wr_data <= rx_word;
              addr    <= next_addr;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end else if (sclk_fall && bit_cnt != '0) begin
          // No shift on the fall after a word's last bit: the fresh word's MSB must stay up.
          tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
`ifdef SPIREG_WSTROBE_EN
      wstrobe <= '0;
`endif
    end else begin
`ifdef SPIREG_WSTROBE_EN
      wstrobe <= '0;
`endif
      for (int i = 0; i < NREG; i++) begin
        if (wr_pend && wr_addr == AW'(i)) begin
          regs[i] <= wr_data;
`ifdef SPIREG_WSTROBE_EN
          wstrobe[i] <= 1'b1;
`endif
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NREG; g++) begin : g_regs_out
      assign regs_out[g*DATA_W +: DATA_W] = regs[g];
    end
  endgenerate

  assign mux  = regs[0][MUX_W-1:0];
  assign miso = miso_oe & tx_sh[DATA_W-1];

endmodule

// File: tb/tb_spi_regfile_slave.sv
// tb/tb_spi_regfile_slave.sv - directed scoreboard bench for spi_regfile_slave
module tb_spi_regfile_slave;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ss;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [1:0]  mux;
  logic [31:0] regs_out;
  logic [31:0] stat_in;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  spi_regfile_slave #(.DATA_W(8), .NREG(4), .MUX_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .ss(ss), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .mux(mux), .regs_out(regs_out), .stat_in(stat_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift one bit; the master samples miso just before raising sclk.
  task automatic spi_bit(input logic b, output logic s);
    mosi = b;
    wait_clk(5);
    s = miso;
    sclk = 1'b1;
    wait_clk(5);
    sclk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] d);
    logic [7:0] rx;
    logic s;
    rx = '0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(d[i], s);
      rx = {rx[6:0], s};
    end
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL miso_word: observed %h expected <none queued>", rx);
    end else begin
      check("miso_word", {24'h0, rx}, {24'h0, exp_q.pop_front()});
    end
  endtask

  task automatic frame_begin();
    ss = 1'b0;
    wait_clk(6);
  endtask

  task automatic frame_end();
    wait_clk(6);
    ss = 1'b1;
    wait_clk(10);
  endtask

  initial begin
    logic s;
    reset_n = 1'b0;
    ss = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    stat_in = 32'h0;
    wait_clk(4);
    check("reset_regs", regs_out, 32'h0);
    check("reset_mux", {30'h0, mux}, 32'h0);
    check("reset_miso", {31'h0, miso}, 32'h0);
    check("reset_oe", {31'h0, miso_oe}, 32'h0);
    reset_n = 1'b1;
    wait_clk(6);

    // Clocking with ss high must be ignored.
    for (int i = 0; i < 8; i++) begin
      spi_bit(1'b1, s);
      check("idle_miso", {31'h0, s}, 32'h0);
    end
    check("idle_oe", {31'h0, miso_oe}, 32'h0);
    check("idle_regs", regs_out, 32'h0);

    // Write reg0 = 0x02; data-word readback shows the old value.
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h00);
    frame_begin();
    check("frame_oe", {31'h0, miso_oe}, 32'h1);
    xfer(8'h80);
    xfer(8'h02);
    frame_end();
    check("wr_reg0", regs_out, 32'h0000_0002);
    check("wr_mux", {30'h0, mux}, 32'h2);

    // Read from address 0 with auto-increment.
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h00);
    frame_begin();
    xfer(8'h00);
    xfer(8'h00);
    xfer(8'h00);
    frame_end();

    // Status word 1 at address 5.
    stat_in = 32'h3344_5A66;
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h5A);
    frame_begin();
    xfer(8'h05);
    xfer(8'h00);
    frame_end();
    check("rd_stat_regs", regs_out, 32'h0000_0002);

    // Write reg3 then run into the read-only status region.
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h66);
    frame_begin();
    xfer(8'h83);
    xfer(8'h11);
    xfer(8'h22);
    frame_end();
    check("wr_reg3", regs_out, 32'h1100_0002);

    // Abort mid data word: no write, err reported in the next status word only.
    exp_q.push_back(8'hA0);
    frame_begin();
    xfer(8'h81);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, s);
    frame_end();
    check("abort_regs", regs_out, 32'h1100_0002);
    exp_q.push_back(8'hA1);
    frame_begin();
    xfer(8'h00);
    frame_end();
    exp_q.push_back(8'hA0);
    frame_begin();
    xfer(8'h00);
    frame_end();

    // Address wrap 7 -> 0.
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h02);
    frame_begin();
    xfer(8'h07);
    xfer(8'h00);
    xfer(8'h00);
    frame_end();
    check("final_regs", regs_out, 32'h1100_0002);
    check("final_oe", {31'h0, miso_oe}, 32'h0);
    check("queue_drained", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
